// File: rtl/ball_physics_sequencer.sv
// Per-frame ball physics: shares the collision-ROM port between video scan and blanking-time probes.
// Optional macro BALL_BOUNCE_EN: a hit reflects that axis instead of resetting the ball to its start.
module ball_physics_sequencer #(
    parameter int H_ACTIVE          = 800,
    parameter int V_ACTIVE          = 600,
    parameter int BALL_R            = 10,
    parameter int MAX_SPEED         = 15,
    parameter int DECEL             = 1,
    parameter int FRAMES_PER_ACTION = 5,
    parameter int START_X           = 200,
    parameter int START_Y           = 300,
    parameter int ROM_LATENCY       = 1
) (
    input  logic               pixel_clk,
    input  logic               rst,
    input  logic [9:0]         h_coord,
    input  logic [9:0]         v_coord,
    input  logic               button_u,
    input  logic               button_d,
    input  logic               button_l,
    input  logic               button_r,
    output logic [18:0]        rom_addr,
    input  logic               rom_data_x,
    input  logic               rom_data_y,
    output logic               pix_wall_x,
    output logic               pix_wall_y,
    output logic [9:0]         ball_x,
    output logic [9:0]         ball_y,
    output logic signed [9:0]  speed_x,
    output logic signed [9:0]  speed_y,
    output logic               busy,
    output logic               update_done,
    output logic               overrun
);
    typedef enum logic [3:0] {
        S_IDLE, S_ACCEL, S_PROBE_X, S_WAIT_X, S_PROBE_Y, S_WAIT_Y, S_RESOLVE, S_DECAY, S_DONE
    } state_t;

    localparam logic signed [11:0] L_MAX = 12'(MAX_SPEED);
    localparam logic signed [11:0] L_R   = 12'(BALL_R);
    localparam logic signed [11:0] L_HA  = 12'(H_ACTIVE);
    localparam logic signed [11:0] L_VA  = 12'(V_ACTIVE);
    localparam logic signed [9:0]  L_DEC = 10'(DECEL);

    state_t            r_state;
    logic              r_trig, r_busy, r_done, r_overrun;
    logic              r_hit_x, r_hit_y;
    logic [9:0]        r_ball_x, r_ball_y, r_wx, r_wy;
    logic signed [9:0] r_sx, r_sy, r_wsx, r_wsy;
    logic [7:0]        r_cnt, r_cnt_w, r_wait;
    logic [ROM_LATENCY-1:0] r_vid_p;

    logic signed [11:0] w_bx, w_by, w_sx12, w_sy12, w_nx, w_ny, w_ax, w_ay;
    logic signed [11:0] w_pa, w_pb;
    logic               w_on_x, w_zero, w_oob, w_rd, w_hit_now, w_phys;
    logic [18:0]        w_paddr, w_scan;

    function automatic logic signed [9:0] sat_speed(input logic signed [11:0] s);
        logic signed [11:0] c;
        c = s;
        if (s > L_MAX)
            c = L_MAX;
        else if (s < -L_MAX)
            c = -L_MAX;
        return c[9:0];
    endfunction

    function automatic logic signed [9:0] decay_speed(input logic signed [9:0] s);
        if (s > L_DEC)
            return s - L_DEC;
        if (s < -L_DEC)
            return s + L_DEC;
        return '0;
    endfunction

    assign w_bx   = {2'b00, r_wx};
    assign w_by   = {2'b00, r_wy};
    assign w_sx12 = {{2{r_wsx[9]}}, r_wsx};
    assign w_sy12 = {{2{r_wsy[9]}}, r_wsy};
    assign w_nx   = w_bx + w_sx12;
    assign w_ny   = w_by + w_sy12;
    assign w_ax   = $signed({11'b0, button_r}) - $signed({11'b0, button_l});
    assign w_ay   = $signed({11'b0, button_d}) - $signed({11'b0, button_u});

    // Probe point: leading edge of the ball along the moving axis, other axis at the current centre.
    assign w_on_x    = (r_state == S_PROBE_X) || (r_state == S_WAIT_X);
    assign w_pa      = w_on_x ? (w_nx + (r_wsx[9] ? -L_R : L_R)) : w_bx;
    assign w_pb      = w_on_x ? w_by : (w_ny + (r_wsy[9] ? -L_R : L_R));
    assign w_zero    = w_on_x ? (r_wsx == 10'sd0) : (r_wsy == 10'sd0);
    assign w_oob     = (w_pa < 12'sd0) || (w_pa >= L_HA) || (w_pb < 12'sd0) || (w_pb >= L_VA);
    assign w_rd      = !w_zero && !w_oob;
    assign w_paddr   = w_rd ? (19'(w_pb[9:0]) * 19'(H_ACTIVE) + 19'(w_pa[9:0])) : '0;
    assign w_hit_now = w_zero ? 1'b0 : (w_oob ? 1'b1 : (w_on_x ? rom_data_x : rom_data_y));

    assign w_scan   = 19'(v_coord) * 19'(H_ACTIVE) + 19'(h_coord);
    assign w_phys   = (r_state != S_IDLE) && (v_coord >= 10'(V_ACTIVE));
    assign rom_addr = rst ? '0 : (w_phys ? w_paddr : w_scan);

    assign pix_wall_x  = rom_data_x & r_vid_p[ROM_LATENCY-1];
    assign pix_wall_y  = rom_data_y & r_vid_p[ROM_LATENCY-1];
    assign ball_x      = r_ball_x;
    assign ball_y      = r_ball_y;
    assign speed_x     = r_sx;
    assign speed_y     = r_sy;
    assign busy        = r_busy;
    assign update_done = r_done;
    assign overrun     = r_overrun;

    always_ff @(posedge pixel_clk or posedge rst) begin
        if (rst) begin
            r_vid_p <= '0;
        end else begin
            r_vid_p[0] <= !w_phys;
            for (int i = 1; i < ROM_LATENCY; i++)
                r_vid_p[i] <= r_vid_p[i-1];
        end
    end

    always_ff @(posedge pixel_clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_trig    <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_overrun <= 1'b0;
            r_hit_x   <= 1'b0;
            r_hit_y   <= 1'b0;
            r_ball_x  <= 10'(START_X);
            r_ball_y  <= 10'(START_Y);
            r_wx      <= 10'(START_X);
            r_wy      <= 10'(START_Y);
            r_sx      <= '0;
            r_sy      <= '0;
            r_wsx     <= '0;
            r_wsy     <= '0;
            r_cnt     <= '0;
            r_cnt_w   <= '0;
            r_wait    <= '0;
        end else begin
            r_trig <= (h_coord == 10'(H_ACTIVE-1)) && (v_coord == 10'(V_ACTIVE-1));
            r_done <= 1'b0;
            // Scan re-entering the active area abandons the update; committed state is untouched.
            if (r_state != S_IDLE && v_coord < 10'(V_ACTIVE)) begin
                r_state   <= S_IDLE;
                r_busy    <= 1'b0;
                r_overrun <= 1'b1;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (r_trig) begin
                            r_state <= S_ACCEL;
                            r_busy  <= 1'b1;
                        end
                    end
                    S_ACCEL: begin
                        r_wx    <= r_ball_x;
                        r_wy    <= r_ball_y;
                        r_wsx   <= sat_speed({{2{r_sx[9]}}, r_sx} + w_ax);
                        r_wsy   <= sat_speed({{2{r_sy[9]}}, r_sy} + w_ay);
                        r_state <= S_PROBE_X;
                    end
                    S_PROBE_X: begin
                        r_wait  <= '0;
                        r_state <= S_WAIT_X;
                    end
                    S_WAIT_X: begin
                        if (r_wait == 8'(ROM_LATENCY-1)) begin
                            r_hit_x <= w_hit_now;
                            r_state <= S_PROBE_Y;
                        end else begin
                            r_wait <= r_wait + 8'd1;
                        end
                    end
                    S_PROBE_Y: begin
                        r_wait  <= '0;
                        r_state <= S_WAIT_Y;
                    end
                    S_WAIT_Y: begin
                        if (r_wait == 8'(ROM_LATENCY-1)) begin
                            r_hit_y <= w_hit_now;
                            r_state <= S_RESOLVE;
                        end else begin
                            r_wait <= r_wait + 8'd1;
                        end
                    end
                    S_RESOLVE: begin
`ifdef BALL_BOUNCE_EN
                        if (r_hit_x) r_wsx <= -r_wsx;
                        else         r_wx  <= w_nx[9:0];
                        if (r_hit_y) r_wsy <= -r_wsy;
                        else         r_wy  <= w_ny[9:0];
`else
                        if (r_hit_x || r_hit_y) begin
                            r_wx  <= 10'(START_X);
                            r_wy  <= 10'(START_Y);
                            r_wsx <= '0;
                            r_wsy <= '0;
                        end else begin
                            r_wx <= w_nx[9:0];
                            r_wy <= w_ny[9:0];
                        end
`endif
                        r_state <= S_DECAY;
                    end
                    S_DECAY: begin
                        if (r_cnt == 8'(FRAMES_PER_ACTION-1)) begin
                            r_cnt_w <= '0;
                            r_wsx   <= decay_speed(r_wsx);
                            r_wsy   <= decay_speed(r_wsy);
                        end else begin
                            r_cnt_w <= r_cnt + 8'd1;
                        end
                        r_state <= S_DONE;
                    end
                    S_DONE: begin
                        r_ball_x <= r_wx;
                        r_ball_y <= r_wy;
                        r_sx     <= r_wsx;
                        r_sy     <= r_wsy;
                        r_cnt    <= r_cnt_w;
                        r_done   <= 1'b1;
                        r_busy   <= 1'b0;
                        r_state  <= S_IDLE;
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_ball_physics_sequencer.sv
// Scoreboard bench for ball_physics_sequencer: directed frames, hand-computed results, edge and abort cases.
module tb_ball_physics_sequencer;
    logic              pixel_clk = 1'b0;
    logic              rst = 1'b1;
    logic [9:0]        h_coord = '0;
    logic [9:0]        v_coord = '0;
    logic              button_u = 1'b0, button_d = 1'b0, button_l = 1'b0, button_r = 1'b0;
    logic [18:0]       rom_addr;
    logic              rom_data_x = 1'b0, rom_data_y = 1'b0;
    logic              pix_wall_x, pix_wall_y;
    logic [9:0]        ball_x, ball_y;
    logic signed [9:0] speed_x, speed_y;
    logic              busy, update_done, overrun;
    logic [18:0]       wall_x_addr = '1;
    logic [18:0]       wall_y_addr = '1;

    typedef struct {int x; int y; int sx; int sy;} st_t;
    st_t exp_q[$];
    int  n_cmp = 0;
    int  n_bad = 0;
    int  m_x = 200, m_y = 300, m_sx = 0, m_sy = 0, m_cnt = 0;

    bit tbl_r[11] = '{1, 1, 1, 0, 0, 1, 1, 0, 1, 0, 0};
    bit tbl_d[11] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1};
    int tbl_y[11] = '{300, 300, 300, 300, 300, 300, 300, 300, 300, 300, 300};
`ifdef BALL_BOUNCE_EN
    int tbl_x[11]  = '{201, 203, 206, 209, 212, 215, 219, 219, 216, 213, 211};
    int tbl_sx[11] = '{1, 2, 3, 3, 2, 3, 4, -4, -3, -2, -2};
    int tbl_sy[11] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, -1};
    localparam logic [18:0] WALL_Y = 19'd249013;
`else
    int tbl_x[11]  = '{201, 203, 206, 209, 212, 215, 219, 200, 201, 202, 200};
    int tbl_sx[11] = '{1, 2, 3, 3, 2, 3, 4, 0, 1, 0, 0};
    int tbl_sy[11] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    localparam logic [18:0] WALL_Y = 19'd249002;
`endif

    always #5 pixel_clk = ~pixel_clk;

    ball_physics_sequencer dut (
        .pixel_clk(pixel_clk), .rst(rst), .h_coord(h_coord), .v_coord(v_coord),
        .button_u(button_u), .button_d(button_d), .button_l(button_l), .button_r(button_r),
        .rom_addr(rom_addr), .rom_data_x(rom_data_x), .rom_data_y(rom_data_y),
        .pix_wall_x(pix_wall_x), .pix_wall_y(pix_wall_y),
        .ball_x(ball_x), .ball_y(ball_y), .speed_x(speed_x), .speed_y(speed_y),
        .busy(busy), .update_done(update_done), .overrun(overrun)
    );

    // One-cycle-latency collision ROMs holding at most one wall pixel each.
    always @(posedge pixel_clk) begin
        rom_data_x <= (rom_addr == wall_x_addr);
        rom_data_y <= (rom_addr == wall_y_addr);
    end

    task automatic chk(input string nm, input int act, input int req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0d, required %0d", nm, act, req);
        end
    endtask

    function automatic int clampi(input int s);
        return (s > 15) ? 15 : ((s < -15) ? -15 : s);
    endfunction

    function automatic int decayi(input int s);
        if (s > 1) return s - 1;
        if (s < -1) return s + 1;
        return 0;
    endfunction

    function automatic bit probe(input int px, input int py, input bit active, input logic [18:0] wall);
        if (!active) return 1'b0;
        if (px < 0 || px >= 800 || py < 0 || py >= 600) return 1'b1;
        return (19'(py * 800 + px) == wall);
    endfunction

    task automatic model_update(input bit u, input bit d, input bit l, input bit r);
        int sx, sy, nx, ny;
        bit hx, hy;
        st_t e;
        sx = clampi(m_sx + int'(r) - int'(l));
        sy = clampi(m_sy + int'(d) - int'(u));
        nx = m_x + sx;
        ny = m_y + sy;
        hx = probe(nx + ((sx < 0) ? -10 : 10), m_y, sx != 0, wall_x_addr);
        hy = probe(m_x, ny + ((sy < 0) ? -10 : 10), sy != 0, wall_y_addr);
`ifdef BALL_BOUNCE_EN
        if (hx) sx = -sx; else m_x = nx;
        if (hy) sy = -sy; else m_y = ny;
`else
        if (hx || hy) begin
            m_x = 200; m_y = 300; sx = 0; sy = 0;
        end else begin
            m_x = nx; m_y = ny;
        end
`endif
        if (m_cnt == 4) begin
            m_cnt = 0; sx = decayi(sx); sy = decayi(sy);
        end else begin
            m_cnt++;
        end
        m_sx = sx;
        m_sy = sy;
        e.x = m_x; e.y = m_y; e.sx = m_sx; e.sy = m_sy;
        exp_q.push_back(e);
    endtask

    // Monitor: every update_done pulse consumes one expected state.
    always @(negedge pixel_clk) begin
        if (!rst && update_done) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_update_done", 1, 0);
            end else begin
                st_t e;
                e = exp_q.pop_front();
                chk("sb_ball_x", int'(ball_x), e.x);
                chk("sb_ball_y", int'(ball_y), e.y);
                chk("sb_speed_x", int'(speed_x), e.sx);
                chk("sb_speed_y", int'(speed_y), e.sy);
            end
        end
    end

    task automatic frame(input bit u, input bit d, input bit l, input bit r,
                         input bit pchk, input int paddr);
        button_u = u; button_d = d; button_l = l; button_r = r;
        h_coord = 10'd799; v_coord = 10'd599;
        @(posedge pixel_clk); #1;
        h_coord = 10'd0; v_coord = 10'd600;
        model_update(u, d, l, r);
        repeat (3) @(posedge pixel_clk);
        #1;
        if (pchk) begin
            chk("pix_wall_x_gated", int'(pix_wall_x), 0);
            chk("probe_x_addr", int'(rom_addr), paddr);
        end
        repeat (11) @(posedge pixel_clk);
        #1;
        v_coord = 10'd0;
        button_u = 0; button_d = 0; button_l = 0; button_r = 0;
        @(posedge pixel_clk); #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit, got timeout, required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        h_coord = 10'd5; v_coord = 10'd7;
        repeat (3) @(posedge pixel_clk);
        #1;
        chk("rst_ball_x", int'(ball_x), 200);
        chk("rst_ball_y", int'(ball_y), 300);
        chk("rst_speed_x", int'(speed_x), 0);
        chk("rst_speed_y", int'(speed_y), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(update_done), 0);
        chk("rst_overrun", int'(overrun), 0);
        chk("rst_pix", int'({pix_wall_x, pix_wall_y}), 0);
        chk("rst_rom_addr", int'(rom_addr), 0);
        rst = 1'b0;
        #1;
        chk("scan_addr", int'(rom_addr), 5605);
        wall_x_addr = 19'd5605;
        @(posedge pixel_clk); #1;
        chk("pix_wall_x_video", int'(pix_wall_x), 1);
        chk("pix_wall_y_video", int'(pix_wall_y), 0);
        wall_x_addr = '1;
        @(posedge pixel_clk); #1;

        // Acceleration, decay, x-wall hit, y-wall hit.
        for (int i = 0; i < 11; i++) begin
            if (i == 7) wall_x_addr = 19'd240233;
            if (i == 10) wall_y_addr = WALL_Y;
            frame(1'b0, tbl_d[i], 1'b0, tbl_r[i], i == 7, 240233);
            wall_x_addr = '1;
            wall_y_addr = '1;
            chk("hand_ball_x", int'(ball_x), tbl_x[i]);
            chk("hand_ball_y", int'(ball_y), tbl_y[i]);
            chk("hand_speed_x", int'(speed_x), tbl_sx[i]);
            chk("hand_speed_y", int'(speed_y), tbl_sy[i]);
        end

        // Long runs into every screen edge, then opposite-button pairs.
        repeat (25) frame(0, 0, 0, 1, 0, 0);
        repeat (3)  frame(0, 0, 0, 0, 0, 0);
        repeat (30) frame(0, 0, 1, 0, 0, 0);
        repeat (25) frame(0, 1, 0, 0, 0, 0);
        repeat (45) frame(1, 0, 0, 0, 0, 0);
        repeat (2)  frame(0, 0, 1, 1, 0, 0);
        repeat (2)  frame(1, 1, 0, 0, 0, 0);

        // Abort during PROBE_Y.
        h_coord = 10'd799; v_coord = 10'd599;
        @(posedge pixel_clk); #1;
        h_coord = 10'd0; v_coord = 10'd600;
        repeat (4) @(posedge pixel_clk);
        #1;
        chk("busy_in_probe_y", int'(busy), 1);
        v_coord = 10'd100; h_coord = 10'd10;
        #1;
        chk("abort_video_addr", int'(rom_addr), 80010);
        @(posedge pixel_clk); #1;
        chk("abort_overrun", int'(overrun), 1);
        chk("abort_busy", int'(busy), 0);
        chk("abort_ball_x", int'(ball_x), m_x);
        chk("abort_ball_y", int'(ball_y), m_y);
        chk("abort_speed_x", int'(speed_x), m_sx);
        chk("abort_speed_y", int'(speed_y), m_sy);
        repeat (12) @(posedge pixel_clk);
        #1;
        v_coord = 10'd0;
        @(posedge pixel_clk); #1;
        frame(0, 0, 0, 0, 0, 0);

        // Reset in the middle of PROBE_X.
        h_coord = 10'd799; v_coord = 10'd599;
        @(posedge pixel_clk); #1;
        h_coord = 10'd0; v_coord = 10'd600;
        repeat (2) @(posedge pixel_clk);
        #1;
        chk("busy_in_probe_x", int'(busy), 1);
        rst = 1'b1;
        #1;
        chk("midrst_ball_x", int'(ball_x), 200);
        chk("midrst_ball_y", int'(ball_y), 300);
        chk("midrst_speed", int'({speed_x, speed_y}), 0);
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_overrun", int'(overrun), 0);
        chk("midrst_rom_addr", int'(rom_addr), 0);
        m_x = 200; m_y = 300; m_sx = 0; m_sy = 0; m_cnt = 0;
        @(posedge pixel_clk); #1;
        rst = 1'b0;
        h_coord = 10'd3; v_coord = 10'd2;
        #1;
        chk("post_rst_scan_addr", int'(rom_addr), 1603);
        frame(0, 0, 0, 1, 0, 0);
        chk("post_rst_ball_x", int'(ball_x), 201);

        repeat (5) @(posedge pixel_clk);
        #1;
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
